pipelined_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the ODE-solver datapath, and the successor to the single-cycle combinational Add_Sub. It splits the carry chain into NUM_STAGES registered slices and adds a per-operation add/sub select and optional saturation. A valid/ready handshake on both sides allows a full-rate stream with backpressure.

---
 rtl/add_sub_pkg.sv | 11 +
 rtl/add_sub_slice.sv | 12 +
 rtl/pipelined_add_sub.sv | 99 +++++++++
 tb/tb_pipelined_add_sub.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared width defaults and saturation limits for the pipelined adder/subtractor
package add_sub_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int MAX_W = 64;
   function automatic logic [MAX_W-1:0] sat_max(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction
   function automatic logic [MAX_W-1:0] sat_min(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction
endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice: combinational W-bit ripple adder slice with carry in/out
module add_sub_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: carry-sliced two's-complement add/sub with valid/ready, global stall
// and optional saturation; all slice results emerge together after NUM_STAGES cycles.
module pipelined_add_sub
   import add_sub_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_STAGES = 4,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  overflow
);
   localparam int W = DATA_WIDTH / NUM_STAGES;
   localparam int M = DATA_WIDTH - 1;
   localparam logic [MAX_W-1:0] SMAX_L = sat_max(DATA_WIDTH);
   localparam logic [MAX_W-1:0] SMIN_L = sat_min(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] SAT_MAX = SMAX_L[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = SMIN_L[DATA_WIDTH-1:0];

   logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] a_r, b_r, s_r, a_in, b_in, s_in, s_nx;
   logic [NUM_STAGES-1:0] v_r, c_r, v_in, c_in, sl_c;
   logic [DATA_WIDTH-1:0] a_last, b_last, raw, res_nx;
   logic adv, ov_nx, ov_r, unused;

   assign adv       = !v_r[NUM_STAGES-1] | out_ready;
   assign in_ready  = adv;
   assign out_valid = v_r[NUM_STAGES-1];
   assign result    = s_r[NUM_STAGES-1];
   assign overflow  = ov_r;
   assign unused    = ^{a_r, b_r, c_r, s_r};

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
      logic [W-1:0] sl_s;
      logic [DATA_WIDTH-1:0] nx;
      if (k == 0) begin : g_in
         assign a_in[k] = A;
         assign b_in[k] = B ^ {DATA_WIDTH{sub}};
         assign s_in[k] = '0;
         assign c_in[k] = sub;
         assign v_in[k] = in_valid;
      end else begin : g_pipe
         assign a_in[k] = a_r[k-1];
         assign b_in[k] = b_r[k-1];
         assign s_in[k] = s_r[k-1];
         assign c_in[k] = c_r[k-1];
         assign v_in[k] = v_r[k-1];
      end
      add_sub_slice #(.W(W)) u_slice (
         .a   (a_in[k][k*W +: W]),
         .b   (b_in[k][k*W +: W]),
         .cin (c_in[k]),
         .s   (sl_s),
         .cout(sl_c[k])
      );
      always_comb begin
         nx = s_in[k];
         nx[k*W +: W] = sl_s;
      end
      assign s_nx[k] = nx;
   end

   assign a_last = a_in[NUM_STAGES-1];
   assign b_last = b_in[NUM_STAGES-1];
   assign raw    = s_nx[NUM_STAGES-1];

   always_comb begin
      ov_nx  = (a_last[M] == b_last[M]) & (raw[M] != a_last[M]);
      res_nx = (SATURATE && ov_nx) ? (a_last[M] ? SAT_MIN : SAT_MAX) : raw;
   end

   // The last stage register holds the finished (possibly clamped) result.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_r  <= '0;
         c_r  <= '0;
         a_r  <= '0;
         b_r  <= '0;
         s_r  <= '0;
         ov_r <= 1'b0;
      end else if (adv) begin
         v_r  <= v_in;
         c_r  <= sl_c;
         a_r  <= a_in;
         b_r  <= b_in;
         s_r  <= s_nx;
         s_r[NUM_STAGES-1] <= res_nx;
         ov_r <= ov_nx;
      end
   end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: randomized and directed checks of the pipelined adder/subtractor
// against an integer-arithmetic reference, with saturating and wrapping instances.
module tb_pipelined_add_sub;
   logic clk = 1'b0;
   logic rst, in_valid, sub, out_ready;
   logic [15:0] A, B;
   logic in_ready, out_valid, overflow;
   logic [15:0] result;
   logic in_ready_w, out_valid_w, overflow_w;
   logic [15:0] result_w;
   int n_tests = 0;
   int n_fail = 0;
   logic [33:0] exp_q[$];
   logic [33:0] got_q[$];

   always #5 clk = ~clk;

   pipelined_add_sub #(.DATA_WIDTH(16), .NUM_STAGES(4), .SATURATE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .overflow(overflow)
   );

   pipelined_add_sub #(.DATA_WIDTH(16), .NUM_STAGES(4), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .A(A), .B(B),
      .sub(sub), .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
      .overflow(overflow_w)
   );

   // Reference: exact integer result, then clamp or wrap to 16 bits.
   function automatic logic [33:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
      int r;
      logic ov;
      logic [15:0] w, sat;
      r = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
      ov = (r > 32767) || (r < -32768);
      w = 16'(r);
      sat = ov ? ((r > 0) ? 16'h7FFF : 16'h8000) : w;
      return {ov, sat, ov, w};
   endfunction

   task automatic tick();
      bit acc, cons;
      acc  = in_valid && in_ready && !rst;
      cons = out_valid && out_ready && !rst;
      if (cons) got_q.push_back({overflow, result, overflow_w, result_w});
      if (acc) exp_q.push_back(model(A, B, sub));
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [15:0] a, input logic [15:0] b, input logic s,
                             output logic [33:0] obs, output int lat);
      A = a; B = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      obs = {overflow, result, overflow_w, result_w};
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sub = 1'b0;
      tick(); tick();
      rst = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || result !== 16'h0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b r=%h ov=%b, want v=0 r=0000 ov=0", out_valid, result, overflow);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [33:0] obs;
      int lat;
      drive_beat(16'h1234, 16'h0111, 1'b0, obs, lat);
      n_tests++;
      if (obs !== {1'b0, 16'h1345, 1'b0, 16'h1345}) begin
         n_fail++;
         $display("FAIL basic_add: got %h want %h", obs, {1'b0, 16'h1345, 1'b0, 16'h1345});
      end
      n_tests++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d want 4", lat);
      end
   endtask

   task automatic test_borrow();
      logic [33:0] obs;
      int lat;
      drive_beat(16'h1000, 16'h0001, 1'b1, obs, lat);
      n_tests++;
      if (obs !== {1'b0, 16'h0FFF, 1'b0, 16'h0FFF} || lat !== 4) begin
         n_fail++;
         $display("FAIL sub_borrow: got %h lat %0d want %h lat 4", obs, lat, {1'b0, 16'h0FFF, 1'b0, 16'h0FFF});
      end
   endtask

   task automatic test_overflow();
      logic [15:0] va[3] = '{16'h7FFF, 16'h8000, 16'h0000};
      logic [15:0] vb[3] = '{16'h0001, 16'h0001, 16'h8000};
      logic        vs[3] = '{1'b0, 1'b1, 1'b1};
      logic [33:0] ve[3] = '{{1'b1, 16'h7FFF, 1'b1, 16'h8000},
                             {1'b1, 16'h8000, 1'b1, 16'h7FFF},
                             {1'b1, 16'h7FFF, 1'b1, 16'h8000}};
      logic [33:0] obs;
      int lat;
      for (int i = 0; i < 3; i++) begin
         drive_beat(va[i], vb[i], vs[i], obs, lat);
         n_tests++;
         if (obs !== ve[i]) begin
            n_fail++;
            $display("FAIL overflow_case%0d: got %h want %h", i, obs, ve[i]);
         end
      end
   endtask

   task automatic test_stream();
      int cyc = 0, first = -1, last = -1, cnt = 0;
      exp_q.delete(); got_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom); in_valid = 1'b1;
         if (out_valid) begin
            if (first < 0) first = cyc;
            last = cyc; cnt++;
         end
         tick(); cyc++;
      end
      in_valid = 1'b0;
      while (got_q.size() < 20 && cyc < 100) begin
         if (out_valid) begin
            if (first < 0) first = cyc;
            last = cyc; cnt++;
         end
         tick(); cyc++;
      end
      n_tests++;
      if (first !== 4 || last !== 23 || cnt !== 20) begin
         n_fail++;
         $display("FAIL stream_timing: got first=%0d last=%0d cnt=%0d want 4 23 20", first, last, cnt);
      end
      n_tests++;
      if (got_q.size() !== 20) begin
         n_fail++;
         $display("FAIL stream_count: got %0d want 20", got_q.size());
      end
      for (int i = 0; i < 20 && i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL stream_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] sa[12], sb[12];
      logic ss[12];
      logic [15:0] held;
      bit stalled;
      int idx = 0, cyc = 0;
      for (int i = 0; i < 12; i++) begin
         sa[i] = 16'($urandom); sb[i] = 16'($urandom); ss[i] = 1'($urandom);
      end
      exp_q.delete(); got_q.delete();
      while ((idx < 12 || got_q.size() < 12) && cyc < 200) begin
         in_valid = (idx < 12);
         if (idx < 12) begin
            A = sa[idx]; B = sb[idx]; sub = ss[idx];
         end
         out_ready = !(cyc >= 8 && cyc <= 10);
         #1;
         stalled = out_valid && !out_ready;
         held = result;
         if (stalled) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready);
            end
         end
         if (in_valid && in_ready) idx++;
         tick(); cyc++;
         if (stalled) begin
            n_tests++;
            if (result !== held || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_hold cyc%0d: got %h v=%b want %h v=1", cyc, result, out_valid, held);
            end
         end
      end
      out_ready = 1'b1;
      n_tests++;
      if (got_q.size() !== 12 || exp_q.size() !== 12) begin
         n_fail++;
         $display("FAIL bp_count: got %0d outputs / %0d accepted, want 12 / 12", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < 12 && i < got_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int stale = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || result !== 16'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_state: got v=%b r=%h rdy=%b want v=0 r=0000 rdy=1", out_valid, result, in_ready);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) stale++;
         tick();
      end
      n_tests++;
      if (stale !== 0) begin
         n_fail++;
         $display("FAIL midreset_stale: got %0d stale beats want 0", stale);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sub = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_borrow();
      test_overflow();
      test_stream();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
